i2c_slave_byte_ctrl: RTL and testbench

- Byte-level I2C slave (responder) controller: the bus-side counterpart of the master byte controller.
- Samples the open-drain SCL/SDA lines directly and detects START, repeated START and STOP.
- Matches the 7-bit slave address, then receives write bytes or transmits read bytes, driving and sampling the ACK bit.
- Sits between the pad open-drain buffers and a register-file/user interface; no clock stretching.

---
 rtl/i2c_slave_byte_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_i2c_slave_byte_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C slave: synchronises SCL/SDA, detects START/STOP,
// matches a 7-bit address and moves bytes with ACK handling.
module i2c_slave_byte_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Scl_i,
  input  logic       Sda_i,
  output logic       Sda_oen,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  input  logic       Rx_nack,
  input  logic [7:0] Tx_data,
  output logic       Tx_req,
  output logic       Tx_nack,
  output logic       Addr_match,
  output logic       Rw,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK
  } state_t;

  state_t state_q, state_d;

  logic [2:0] scl_sync_q, sda_sync_q;
  logic [2:0] cnt_q, cnt_d;
  logic       done_q, done_d;
  logic [7:0] shift_q, shift_d;
  logic       oen_q, oen_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       tx_nack_q, tx_nack_d;
  logic       match_q, match_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       nack_q, nack_d;

  logic scl_s, scl_h, sda_s, sda_h;
  logic scl_rise, scl_fall, start, stop;

  // [0],[1] synchronise; [2] is history for edge detection
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], Scl_i};
      sda_sync_q <= {sda_sync_q[1:0], Sda_i};
    end
  end

  assign scl_s    = scl_sync_q[1];
  assign scl_h    = scl_sync_q[2];
  assign sda_s    = sda_sync_q[1];
  assign sda_h    = sda_sync_q[2];
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  assign start    = scl_s & scl_h & ~sda_s & sda_h;
  assign stop     = scl_s & scl_h & sda_s & ~sda_h;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    shift_d    = shift_q;
    oen_d      = oen_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    tx_nack_d  = 1'b0;
    match_d    = match_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    nack_d     = nack_q;
    if (start) begin
      state_d = S_ADDR;
      cnt_d   = 3'd7;
      done_d  = 1'b0;
      oen_d   = 1'b1;
      busy_d  = 1'b1;
      match_d = 1'b0;
    end else if (stop) begin
      state_d = S_IDLE;
      oen_d   = 1'b1;
      busy_d  = 1'b0;
      match_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: oen_d = 1'b1;
        S_ADDR: begin
          if (scl_rise && !done_q) begin
            shift_d = {shift_q[6:0], sda_s};
            if (cnt_q == 3'd0) done_d = 1'b1;
            else cnt_d = cnt_q - 3'd1;
          end else if (scl_fall && done_q) begin
            done_d = 1'b0;
            if (shift_q[7:1] == SLAVE_ADDR) begin
              rw_d    = shift_q[0];
              oen_d   = 1'b0;
              match_d = 1'b1;
              state_d = S_ADDR_ACK;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_rise) begin
            tx_req_d = rw_q;
          end else if (scl_fall) begin
            cnt_d = 3'd7;
            if (rw_q) begin
              shift_d = Tx_data;
              oen_d   = Tx_data[7];
              state_d = S_TX;
            end else begin
              oen_d   = 1'b1;
              state_d = S_RX;
            end
          end
        end
        S_RX: begin
          if (scl_rise && !done_q) begin
            shift_d = {shift_q[6:0], sda_s};
            if (cnt_q == 3'd0) begin
              done_d     = 1'b1;
              rx_data_d  = {shift_q[6:0], sda_s};
              rx_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end else if (scl_fall && done_q) begin
            done_d  = 1'b0;
            oen_d   = Rx_nack;
            nack_d  = Rx_nack;
            state_d = S_RX_ACK;
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            oen_d   = 1'b1;
            cnt_d   = 3'd7;
            state_d = nack_q ? S_IDLE : S_RX;
          end
        end
        S_TX: begin
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              oen_d   = 1'b1;
              state_d = S_TX_ACK;
            end else begin
              cnt_d   = cnt_q - 3'd1;
              shift_d = {shift_q[6:0], 1'b0};
              oen_d   = shift_q[6];
            end
          end
        end
        S_TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              tx_nack_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              tx_req_d = 1'b1;
            end
          end else if (scl_fall) begin
            shift_d = Tx_data;
            oen_d   = Tx_data[7];
            cnt_d   = 3'd7;
            state_d = S_TX;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd7;
      done_q     <= 1'b0;
      shift_q    <= 8'h00;
      oen_q      <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      tx_nack_q  <= 1'b0;
      match_q    <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      shift_q    <= shift_d;
      oen_q      <= oen_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      tx_nack_q  <= tx_nack_d;
      match_q    <= match_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      nack_q     <= nack_d;
    end
  end

  assign Sda_oen    = oen_q;
  assign Rx_data    = rx_data_q;
  assign Rx_valid   = rx_valid_q;
  assign Tx_req     = tx_req_q;
  assign Tx_nack    = tx_nack_q;
  assign Addr_match = match_q;
  assign Rw         = rw_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Bench for i2c_slave_byte_ctrl: bit-banged I2C master on a
// wired-AND bus, directed scenarios plus random transfers.
module tb_i2c_slave_byte_ctrl;

  localparam logic [6:0] SA = 7'h50;
  localparam int Q = 10;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       Rx_nack = 1'b0;
  logic [7:0] Tx_data = 8'h00;
  logic       Scl_i, Sda_i;
  logic       Sda_oen, Rx_valid, Tx_req, Tx_nack;
  logic       Addr_match, Rw, Busy;
  logic [7:0] Rx_data;

  assign Scl_i = scl_m;
  assign Sda_i = sda_m & Sda_oen;

  i2c_slave_byte_ctrl #(.SLAVE_ADDR(SA)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Scl_i(Scl_i), .Sda_i(Sda_i),
    .Sda_oen(Sda_oen), .Rx_data(Rx_data), .Rx_valid(Rx_valid),
    .Rx_nack(Rx_nack), .Tx_data(Tx_data), .Tx_req(Tx_req),
    .Tx_nack(Tx_nack), .Addr_match(Addr_match), .Rw(Rw),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int n_rxv = 0, n_txreq = 0, n_txnack = 0;
  int n_oen_low = 0, busy_gap = 0;
  bit mon_busy = 1'b0;
  logic [7:0] rxq[$];

  always @(negedge Clk) begin
    if (Rx_valid) begin
      n_rxv++;
      rxq.push_back(Rx_data);
    end
    if (Tx_req) n_txreq++;
    if (Tx_nack) n_txnack++;
    if (!Sda_oen) n_oen_low++;
    if (mon_busy && !Busy) busy_gap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(Q);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    s = Sda_i; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic mack, input logic [7:0] nxt,
                         output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    Tx_data = nxt;
    clk_bit(~mack, s);
  endtask

  // reference: a header is acknowledged only for our own address
  function automatic logic exp_ack(input logic [7:0] hdr);
    return hdr[7:1] == SA;
  endfunction

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] hdr;
    logic [7:0] b;
    logic [7:0] tx[4];
    logic [7:0] expq[$];
    logic       m, rw;
    int         nb, r0, o0, q0, k0, g0;

    wclk(3);
    chk("rst_oen", Sda_oen, 1);
    chk("rst_rxdata", Rx_data, 8'h00);
    chk("rst_pulses", {Rx_valid, Tx_req, Tx_nack}, 0);
    chk("rst_match_rw_busy", {Addr_match, Rw, Busy}, 0);
    Rst_n = 1'b1;
    wclk(5);

    // write 0x3C, 0xC3
    r0 = n_rxv;
    rxq.delete();
    i2c_start();
    chk("t1_busy", Busy, 1);
    wr_byte(8'hA0, ack);
    chk("t1_hdr_ack", ack, 1);
    chk("t1_match", Addr_match, 1);
    chk("t1_rw", Rw, 0);
    wr_byte(8'h3C, ack);
    chk("t1_d0_ack", ack, 1);
    wr_byte(8'hC3, ack);
    chk("t1_d1_ack", ack, 1);
    i2c_stop();
    wclk(5);
    chk("t1_busy_end", Busy, 0);
    chk("t1_nrx", n_rxv - r0, 2);
    if (rxq.size() == 2) begin
      chk("t1_rx0", rxq[0], 8'h3C);
      chk("t1_rx1", rxq[1], 8'hC3);
    end

    // read 0x96 then 0x5A, master NACKs the second
    q0 = n_txreq; k0 = n_txnack;
    Tx_data = 8'h96;
    i2c_start();
    wr_byte(8'hA1, ack);
    chk("t2_hdr_ack", ack, 1);
    chk("t2_rw", Rw, 1);
    rd_byte(1'b1, 8'h5A, d);
    chk("t2_b0", d, 8'h96);
    rd_byte(1'b0, 8'h00, d);
    chk("t2_b1", d, 8'h5A);
    i2c_stop();
    wclk(5);
    chk("t2_txreq", n_txreq - q0, 2);
    chk("t2_txnack", n_txnack - k0, 1);

    // foreign address 0x51
    r0 = n_rxv; o0 = n_oen_low;
    i2c_start();
    wr_byte(8'hA2, ack);
    chk("t3_hdr_ack", ack, 0);
    chk("t3_match", Addr_match, 0);
    chk("t3_busy", Busy, 1);
    wr_byte(8'h55, ack);
    chk("t3_d_ack", ack, 0);
    i2c_stop();
    wclk(5);
    chk("t3_busy_end", Busy, 0);
    chk("t3_oen_low", n_oen_low - o0, 0);
    chk("t3_nrx", n_rxv - r0, 0);

    // write 0x11, repeated START, read
    r0 = n_rxv; q0 = n_txreq; g0 = busy_gap;
    rxq.delete();
    Tx_data = 8'h3E;
    i2c_start();
    wclk(2);
    mon_busy = 1'b1;
    wr_byte(8'hA0, ack);
    wr_byte(8'h11, ack);
    chk("t4_d_ack", ack, 1);
    i2c_start();
    wr_byte(8'hA1, ack);
    chk("t4_hdr2_ack", ack, 1);
    chk("t4_rw", Rw, 1);
    chk("t4_txreq", n_txreq - q0, 1);
    rd_byte(1'b0, 8'h00, d);
    chk("t4_rd", d, 8'h3E);
    mon_busy = 1'b0;
    i2c_stop();
    wclk(5);
    chk("t4_busy_gap", busy_gap - g0, 0);
    chk("t4_nrx", n_rxv - r0, 1);
    if (rxq.size() == 1) chk("t4_rx", rxq[0], 8'h11);

    // NACK 0x77, following byte ignored
    r0 = n_rxv;
    rxq.delete();
    i2c_start();
    wr_byte(8'hA0, ack);
    Rx_nack = 1'b1;
    wr_byte(8'h77, ack);
    chk("t5_nack", ack, 0);
    Rx_nack = 1'b0;
    wr_byte(8'h55, ack);
    chk("t5_after_ack", ack, 0);
    i2c_stop();
    wclk(5);
    chk("t5_nrx", n_rxv - r0, 1);
    if (rxq.size() == 1) chk("t5_rx", rxq[0], 8'h77);

    // reset while driving a 0 data bit
    Tx_data = 8'h00;
    i2c_start();
    wr_byte(8'hA1, ack);
    chk("t6_driving", Sda_oen, 0);
    Rst_n = 1'b0;
    wclk(1);
    chk("t6_oen", Sda_oen, 1);
    chk("t6_outs", {Addr_match, Rw, Busy, Rx_valid, Tx_req, Tx_nack}, 0);
    chk("t6_rxdata", Rx_data, 8'h00);
    Rst_n = 1'b1;
    wclk(5);
    i2c_stop();
    wclk(5);

    // random transfers against the reference model
    for (int t = 0; t < 10; t++) begin
      m  = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      hdr[7:1] = 7'($urandom_range(0, 127));
      if (m) hdr[7:1] = SA;
      else if (hdr[7:1] == SA) hdr[7:1] = hdr[7:1] ^ 7'h01;
      hdr[0] = rw;
      r0 = n_rxv; q0 = n_txreq; k0 = n_txnack;
      rxq.delete();
      expq.delete();
      for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
      Tx_data = tx[0];
      i2c_start();
      wr_byte(hdr, ack);
      chk("rnd_hdr_ack", ack, exp_ack(hdr));
      if (!rw) begin
        for (int i = 0; i < nb; i++) begin
          b = 8'($urandom);
          if (exp_ack(hdr)) expq.push_back(b);
          wr_byte(b, ack);
          chk("rnd_wr_ack", ack, exp_ack(hdr));
        end
        i2c_stop();
        wclk(5);
        chk("rnd_nrx", n_rxv - r0, expq.size());
        if (rxq.size() == expq.size())
          foreach (expq[i]) chk("rnd_rx", rxq[i], expq[i]);
      end else begin
        for (int i = 0; i < nb; i++) begin
          rd_byte(i != nb - 1, tx[i + 1], d);
          chk("rnd_rd", d, exp_ack(hdr) ? tx[i] : 8'hFF);
        end
        i2c_stop();
        wclk(5);
        chk("rnd_txreq", n_txreq - q0, exp_ack(hdr) ? nb : 0);
        chk("rnd_txnack", n_txnack - k0, exp_ack(hdr) ? 1 : 0);
      end
      chk("rnd_busy_end", Busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
